// File: rtl/gate_test_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : gate_test_sequencer
// Brief    : Drives the four {a,b} vectors into a two-input gate under test.
//            Holds each vector for SETTLE_CYCLES cycles, then samples y
//            against TRUTH. Accumulates per-vector mismatches and reports a
//            pass/fail verdict.
// Revision : 1.0 - initial release
// ============================================================================
module gate_test_sequencer #(
    parameter int         SETTLE_CYCLES = 2,        // legal range 1..15
    parameter logic [3:0] TRUTH         = 4'b0111   // index = {a,b}; NAND
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       y,
    output logic       a,
    output logic       b,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_count,
    output logic [3:0] fail_mask
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_SAMPLE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    // Settle counter value on the last SETTLE cycle of each vector.
    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

    state_t     state;
    logic [1:0] idx;
    logic [3:0] cnt;
    logic       mismatch;

    // Current gate output disagrees with the expected value for this vector.
    always_comb begin
        mismatch = (y != TRUTH[idx]);
    end

    // Sequencer: vector stepping, settle timing, scoring and verdict.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            idx       <= 2'd0;
            cnt       <= 4'd0;
            a         <= 1'b0;
            b         <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_count <= 3'd0;
            fail_mask <= 4'd0;
        end else begin
            case (state)
                // IDLE and DONE share the start behaviour: a restart from
                // DONE wipes the previous results on the same edge.
                S_IDLE, S_DONE: begin
                    if (start) begin
                        err_count <= 3'd0;
                        fail_mask <= 4'd0;
                        idx       <= 2'd0;
                        cnt       <= 4'd0;
                        a         <= 1'b0;
                        b         <= 1'b0;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        pass      <= 1'b0;
                        state     <= S_SETTLE;
                    end
                end

                S_SETTLE: begin
                    cnt <= cnt + 4'd1;
                    if (cnt == SETTLE_LAST) begin
                        state <= S_SAMPLE;
                    end
                end

                S_SAMPLE: begin
                    if (mismatch) begin
                        err_count      <= err_count + 3'd1;
                        fail_mask[idx] <= 1'b1;
                    end
                    if (idx == 2'd3) begin
                        // Verdict must include the mismatch scored this cycle.
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (err_count == 3'd0) && !mismatch;
                        state <= S_DONE;
                    end else begin
                        idx    <= idx + 2'd1;
                        {a, b} <= idx + 2'd1;
                        cnt    <= 4'd0;
                        state  <= S_SETTLE;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_gate_test_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_gate_test_sequencer
// Brief    : Directed self-checking bench for gate_test_sequencer with
//            combinational and delayed gate models at several settle times.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gate_test_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start2 = 1'b0;
    logic start13 = 1'b0;
    int   mode = 0;     // 0: NAND, 1: tied 0, 2: AND

    int checks = 0;
    int passed = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    // DUT with default settle time and a selectable combinational gate
    logic       y2, a2, b2, busy2, done2, pass2;
    logic [2:0] err2;
    logic [3:0] mask2;

    always_comb begin
        y2 = 1'b0;
        if (mode == 0)      y2 = ~(a2 & b2);
        else if (mode == 2) y2 = a2 & b2;
    end

    gate_test_sequencer #(.SETTLE_CYCLES(2), .TRUTH(4'b0111)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .y(y2),
        .a(a2), .b(b2), .busy(busy2), .done(done2), .pass(pass2),
        .err_count(err2), .fail_mask(mask2)
    );

    // DUTs driving a NAND delayed by two registers
    logic       y1, a1, b1, busy1, done1, pass1, d1a, d1b;
    logic [2:0] err1;
    logic [3:0] mask1;
    logic       y3, a3, b3, busy3, done3, pass3, d3a, d3b;
    logic [2:0] err3;
    logic [3:0] mask3;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d1a <= 1'b1; d1b <= 1'b1; d3a <= 1'b1; d3b <= 1'b1;
        end else begin
            d1a <= ~(a1 & b1); d1b <= d1a;
            d3a <= ~(a3 & b3); d3b <= d3a;
        end
    end
    assign y1 = d1b;
    assign y3 = d3b;

    gate_test_sequencer #(.SETTLE_CYCLES(1), .TRUTH(4'b0111)) dut1 (
        .clk(clk), .rst(rst), .start(start13), .y(y1),
        .a(a1), .b(b1), .busy(busy1), .done(done1), .pass(pass1),
        .err_count(err1), .fail_mask(mask1)
    );

    gate_test_sequencer #(.SETTLE_CYCLES(3), .TRUTH(4'b0111)) dut3 (
        .clk(clk), .rst(rst), .start(start13), .y(y3),
        .a(a3), .b(b3), .busy(busy3), .done(done3), .pass(pass3),
        .err_count(err3), .fail_mask(mask3)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) begin
            passed++;
        end else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One-cycle start pulse; returns just after the start edge E0
    task automatic pulse2();
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
    endtask

    // Cycles after E0 until done rises, bounded
    task automatic wait_done2(input int already, output int n);
        n = already;
        while (!done2 && n < 100) begin
            tick();
            n++;
        end
    endtask

    initial begin
        int n;
        int t1;
        int t3;

        // Reset state
        tick();
        check("reset_outputs", 16'({a2, b2, busy2, done2, pass2, err2, mask2}), 16'd0);
        tick();
        rst = 1'b0;
        tick();
        check("idle_no_busy", 16'({busy2, done2}), 16'd0);

        // Correct NAND: vector stepping and completion latency
        mode = 0;
        pulse2();
        check("e0_ab_busy", 16'({a2, b2, busy2, done2}), 16'b0010);
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (k == 3)  check("ab_01", 16'({a2, b2}), 16'd1);
            if (k == 6)  check("ab_10", 16'({a2, b2}), 16'd2);
            if (k == 9)  check("ab_11", 16'({a2, b2}), 16'd3);
            if (k == 11) check("not_done_11", 16'({busy2, done2}), 16'b10);
            if (k == 12) check("done_12", 16'({busy2, done2, a2, b2}), 16'b0111);
        end
        check("nand_result", 16'({pass2, err2, mask2}), 16'({1'b1, 3'd0, 4'b0000}));

        // y tied to 0
        mode = 1;
        pulse2();
        wait_done2(0, n);
        check("zero_latency", 16'(n), 16'd12);
        check("zero_result", 16'({pass2, err2, mask2}), 16'({1'b0, 3'd3, 4'b0111}));

        // y = AND
        mode = 2;
        pulse2();
        wait_done2(0, n);
        check("and_result", 16'({pass2, err2, mask2}), 16'({1'b0, 3'd4, 4'b1111}));

        // Restart from DONE with pass=0 clears results immediately
        mode = 0;
        pulse2();
        check("restart_clear", 16'({done2, busy2, err2, mask2}), 16'({1'b0, 1'b1, 3'd0, 4'd0}));
        wait_done2(0, n);
        check("restart_pass", 16'({pass2, err2, mask2}), 16'({1'b1, 3'd0, 4'd0}));

        // start re-pulsed at cycle 4 is ignored
        pulse2();
        tick(); tick(); tick();
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        wait_done2(4, n);
        check("ignore_start_latency", 16'(n), 16'd12);
        check("ignore_start_pass", 16'({pass2, err2}), 16'({1'b1, 3'd0}));

        // Asynchronous reset at cycle 5, then a full clean run
        pulse2();
        tick(); tick(); tick(); tick();
        #2;
        rst = 1'b1;
        #1;
        check("midrun_reset", 16'({a2, b2, busy2, done2, pass2, err2, mask2}), 16'd0);
        tick();
        rst = 1'b0;
        tick();
        check("post_reset_idle", 16'({busy2, done2}), 16'd0);
        pulse2();
        wait_done2(0, n);
        check("post_reset_latency", 16'(n), 16'd12);
        check("post_reset_pass", 16'({pass2, err2, mask2}), 16'({1'b1, 3'd0, 4'd0}));

        // Delayed NAND with SETTLE_CYCLES = 1 and 3
        start13 = 1'b1;
        tick();
        start13 = 1'b0;
        t1 = 0;
        t3 = 0;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (done1 && t1 == 0) t1 = k;
            if (done3 && t3 == 0) t3 = k;
        end
        check("s1_latency", 16'(t1), 16'd8);
        check("s1_result", 16'({pass1, err1, mask1}), 16'({1'b0, 3'd1, 4'b1000}));
        check("s3_latency", 16'(t3), 16'd16);
        check("s3_result", 16'({pass3, err3, mask3}), 16'({1'b1, 3'd0, 4'd0}));

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
`default_nettype wire
